// File: rtl/l2_probe_scheduler.sv
// rtl/l2_probe_scheduler.sv - Channel B probe sequencer and ProbeAck collector for the L2 directory
module l2_probe_scheduler #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_MASTERS-1:0] req_sharers_i,
    input  logic [1:0]             req_param_i,
    output logic [NUM_MASTERS-1:0] b_valid_o,
    input  logic [NUM_MASTERS-1:0] b_ready_i,
    output logic [ADDR_WIDTH-1:0]  b_address_o,
    output logic [1:0]             b_param_o,
    input  logic                   ack_valid_i,
    input  logic [MID_W-1:0]       ack_master_id_i,
    input  logic                   ack_dirty_i,
    output logic                   ack_ready_o,
    output logic                   done_valid_o,
    input  logic                   done_ready_i,
    output logic                   done_dirty_o,
    output logic [NUM_MASTERS-1:0] done_acked_o,
    output logic                   err_unexp_o,
    output logic                   err_timeout_o,
    output logic                   busy_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] issue_mask;
    logic [NUM_MASTERS-1:0] out_mask;
    logic [NUM_MASTERS-1:0] acked_mask;
    logic                   dirty;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [1:0]             param;
    logic [TW-1:0]          timer;
    logic                   err_unexp;
    logic                   err_timeout;

    logic [NUM_MASTERS-1:0] id_onehot;
    logic [NUM_MASTERS-1:0] ack_clear;
    logic [NUM_MASTERS-1:0] issued;
    logic                   ack_good;
    logic                   ack_bad;
    logic                   probe_fire;

    // Ids beyond NUM_MASTERS decode to no bit, so they can never match out_mask.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ack_master_id_i == MID_W'(i)) id_onehot[i] = 1'b1;
        end
    end

    assign b_valid_o  = (state == ISSUE) ? (issue_mask & (~issue_mask + NUM_MASTERS'(1))) : '0;
    assign probe_fire = |(b_valid_o & b_ready_i);
    assign issued     = probe_fire ? b_valid_o : '0;
    assign ack_good   = ack_valid_i && (state == ISSUE || state == COLLECT) && |(out_mask & id_onehot);
    assign ack_bad    = ack_valid_i && !ack_good;
    assign ack_clear  = ack_good ? id_onehot : '0;

    assign req_ready_o   = (state == IDLE);
    assign ack_ready_o   = ~rst;
    assign busy_o        = (state != IDLE);
    assign done_valid_o  = (state == DONE);
    assign done_dirty_o  = dirty;
    assign done_acked_o  = acked_mask;
    assign err_unexp_o   = err_unexp;
    assign err_timeout_o = err_timeout;
    assign b_address_o   = addr;
    assign b_param_o     = param;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            issue_mask  <= '0;
            out_mask    <= '0;
            acked_mask  <= '0;
            dirty       <= 1'b0;
            addr        <= '0;
            param       <= '0;
            timer       <= '0;
            err_unexp   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            out_mask   <= (out_mask & ~ack_clear) | issued;
            acked_mask <= acked_mask | ack_clear;
            dirty      <= dirty | (ack_good & ack_dirty_i);
            err_unexp  <= err_unexp | ack_bad;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr        <= req_addr_i;
                        param       <= req_param_i;
                        issue_mask  <= req_sharers_i;
                        out_mask    <= '0;
                        acked_mask  <= '0;
                        dirty       <= 1'b0;
                        err_unexp   <= ack_bad;
                        err_timeout <= 1'b0;
                        state       <= (req_sharers_i != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (probe_fire) begin
                        issue_mask <= issue_mask & ~b_valid_o;
                        if ((issue_mask & ~b_valid_o) == '0) begin
                            state <= COLLECT;
                            timer <= '0;
                        end
                    end
                end
                COLLECT: begin
                    // An ack landing on the expiry cycle still counts and restarts the window.
                    if (out_mask == '0) begin
                        state <= DONE;
                    end else if (ack_good) begin
                        timer <= '0;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    if (done_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
